// File: rtl/bcd_adder_2digit_if.sv
// Operand/result bundle for the two-digit packed-BCD adder.
// The master drives the operands. The slave (the adder) returns the registered result.
interface bcd_adder_2digit_if;
  logic       in_vld;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       cout;
  logic [7:0] s;
  logic       out_vld;
  logic       err;

  modport master (
    output in_vld, a, b, cin,
    input  cout, s, out_vld, err
  );

  modport slave (
    input  in_vld, a, b, cin,
    output cout, s, out_vld, err
  );
endinterface : bcd_adder_2digit_if

// File: rtl/bcd_adder_2digit.sv
// Registered two-digit packed-BCD adder with carry-in and carry-out.
// The units digit and the tens digit ripple through c0. The adder corrects
// each digit by adding 6 when the binary digit sum exceeds 9. Any operand
// nibble above 9 is added with the same rule and sets err for that result.
module bcd_adder_2digit (
  input  logic                clk,
  input  logic                rst_n,
  bcd_adder_2digit_if.slave   bus
);

  logic [4:0] t0;
  logic [4:0] t1;
  logic       c0;
  logic [3:0] s0_d;
  logic [3:0] s1_d;
  logic       cout_d;
  logic       err_d;

  logic [7:0] s_q;
  logic       cout_q;
  logic       err_q;
  logic       out_vld_q;

  // Two ripple digit stages with the decimal correction, and the non-BCD flag.
  always_comb begin
    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    s0_d   = 4'd0;
    s1_d   = 4'd0;
    c0     = 1'b0;
    cout_d = 1'b0;

    // The 5-bit sums hold the worst case 15+15+1 = 31 without overflow.
    t0 = {1'b0, bus.a[3:0]} + {1'b0, bus.b[3:0]} + {4'd0, bus.cin};
    if (t0 > 5'd9) begin
      s0_d = t0[3:0] + 4'd6;   // low nibble of (t0 + 6)
      c0   = 1'b1;
    end else begin
      s0_d = t0[3:0];
    end

    t1 = {1'b0, bus.a[7:4]} + {1'b0, bus.b[7:4]} + {4'd0, c0};
    if (t1 > 5'd9) begin
      s1_d   = t1[3:0] + 4'd6;
      cout_d = 1'b1;
    end else begin
      s1_d = t1[3:0];
    end

    err_d = (bus.a[3:0] > 4'd9) || (bus.a[7:4] > 4'd9) ||
            (bus.b[3:0] > 4'd9) || (bus.b[7:4] > 4'd9);
  end

  // The result registers capture on in_vld and hold otherwise. out_vld follows in_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= 8'h00;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      out_vld_q <= bus.in_vld;
      if (bus.in_vld) begin
        s_q    <= {s1_d, s0_d};
        cout_q <= cout_d;
        err_q  <= err_d;
      end
    end
  end

  assign bus.s       = s_q;
  assign bus.cout    = cout_q;
  assign bus.err     = err_q;
  assign bus.out_vld = out_vld_q;

endmodule : bcd_adder_2digit

// File: tb/tb_bcd_adder_2digit.sv
// Self-checking bench for bcd_adder_2digit: directed cases, mid-stream reset,
// an exhaustive sweep over valid operands and random (possibly non-BCD) operands,
// all checked against a decimal reference model.
module tb_bcd_adder_2digit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  bcd_adder_2digit_if bus ();

  bcd_adder_2digit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Reference result {err, cout, s}. For valid operands the model adds the whole
  // numbers in decimal. For non-BCD operands it adds digit by digit: a digit sum
  // above 9 carries and keeps (sum + 6) mod 16.
  function automatic logic [9:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int   total;
    int   u;
    int   t;
    int   c;
    logic [7:0] s;
    logic co;
    if (is_bcd(a) && is_bcd(b)) begin
      total = (int'(a[7:4]) * 10 + int'(a[3:0])) + (int'(b[7:4]) * 10 + int'(b[3:0])) + int'(cin);
      co = (total >= 100);
      total = total % 100;
      s = {4'(total / 10), 4'(total % 10)};
      return {1'b0, co, s};
    end
    u = int'(a[3:0]) + int'(b[3:0]) + int'(cin);
    c = (u > 9) ? 1 : 0;
    if (c == 1) u = (u + 6) % 16;
    t = int'(a[7:4]) + int'(b[7:4]) + c;
    co = (t > 9);
    if (co) t = (t + 6) % 16;
    s = {4'(t), 4'(u)};
    return {1'b1, co, s};
  endfunction

  // The task drives one operand set, then samples the outputs 1 ns after the capturing edge.
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic cin, input string tag);
    logic [9:0] exp;
    exp = ref_add(a, b, cin);
    bus.in_vld = 1'b1;
    bus.a      = a;
    bus.b      = b;
    bus.cin    = cin;
    @(posedge clk);
    #1;
    check({tag, ".s"},       32'(bus.s),       32'(exp[7:0]));
    check({tag, ".cout"},    32'(bus.cout),    32'(exp[8]));
    check({tag, ".err"},     32'(bus.err),     32'(exp[9]));
    check({tag, ".out_vld"}, 32'(bus.out_vld), 32'd1);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [7:0] va;
    logic [7:0] vb;
    n_checks   = 0;
    n_errors   = 0;
    bus.in_vld = 1'b0;
    bus.a      = 8'h00;
    bus.b      = 8'h00;
    bus.cin    = 1'b0;
    rst_n      = 1'b1;
    #2 rst_n   = 1'b0;
    #1;
    check("reset.s",       32'(bus.s),       32'h00);
    check("reset.cout",    32'(bus.cout),    32'd0);
    check("reset.err",     32'(bus.err),     32'd0);
    check("reset.out_vld", 32'(bus.out_vld), 32'd0);
    @(posedge clk);
    #1;
    check("reset_held.out_vld", 32'(bus.out_vld), 32'd0);
    rst_n = 1'b1;

    // Directed cases
    apply(8'h99, 8'h99, 1'b0, "d_99_99");
    check("d_99_99.s_lit",    32'(bus.s),    32'h98);
    check("d_99_99.cout_lit", 32'(bus.cout), 32'd1);
    apply(8'h12, 8'h12, 1'b0, "d_12_12");
    check("d_12_12.s_lit", 32'(bus.s), 32'h24);
    apply(8'h55, 8'h55, 1'b0, "d_55_55");
    check("d_55_55.s_lit", 32'(bus.s), 32'h10);
    apply(8'h13, 8'h54, 1'b0, "d_13_54");
    check("d_13_54.s_lit", 32'(bus.s), 32'h67);
    apply(8'h19, 8'h91, 1'b0, "d_19_91");
    check("d_19_91.s_lit", 32'(bus.s), 32'h10);
    apply(8'h99, 8'h00, 1'b1, "d_99_00_c");
    check("d_99_00_c.s_lit",    32'(bus.s),    32'h00);
    check("d_99_00_c.cout_lit", 32'(bus.cout), 32'd1);
    apply(8'hFF, 8'hFF, 1'b1, "d_ff_ff_c");
    apply(8'h0A, 8'h00, 1'b0, "d_0a_00");
    check("d_0a_00.err_lit", 32'(bus.err), 32'd1);

    // Without in_vld the outputs hold and out_vld drops.
    bus.in_vld = 1'b0;
    bus.a      = 8'h47;
    bus.b      = 8'h38;
    @(posedge clk);
    #1;
    check("hold.out_vld", 32'(bus.out_vld), 32'd0);
    check("hold.s",       32'(bus.s),       32'h10);
    check("hold.err",     32'(bus.err),     32'd1);

    // A valid capture, then a reset mid-stream with an operand in flight
    apply(8'h47, 8'h38, 1'b1, "pre_rst");
    bus.a = 8'h99;
    bus.b = 8'h99;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.s",       32'(bus.s),       32'h00);
    check("mid_rst.cout",    32'(bus.cout),    32'd0);
    check("mid_rst.err",     32'(bus.err),     32'd0);
    check("mid_rst.out_vld", 32'(bus.out_vld), 32'd0);
    bus.in_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst.out_vld", 32'(bus.out_vld), 32'd0);
    check("post_rst.s",       32'(bus.s),       32'h00);

    // Exhaustive sweep over valid operands and both carry-in values
    for (int i = 0; i < 100; i++) begin
      for (int j = 0; j < 100; j++) begin
        for (int c = 0; c < 2; c++) begin
          va = {4'(i / 10), 4'(i % 10)};
          vb = {4'(j / 10), 4'(j % 10)};
          apply(va, vb, 1'(c), "sweep");
        end
      end
    end

    // Random operands, including non-BCD nibbles
    for (int k = 0; k < 500; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      apply(ra, rb, rc, "rand");
    end

    bus.in_vld = 1'b0;
    @(posedge clk);
    #1;
    check("idle.out_vld", 32'(bus.out_vld), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_bcd_adder_2digit
